ifetch_queue: RTL and testbench



---
 rtl/ifetch_pkg.sv | 31 +++
 rtl/fifo_sync.sv | 71 +++++++
 rtl/ifetch_queue_checker.sv | 23 ++
 rtl/ifetch_queue.sv | 165 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the pipelined instruction-fetch queue.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam int EXC_ADEL_BIT    = 14;
    localparam int EXC_TLBMISS_BIT = 15;
    localparam int EXC_TLBINV_BIT  = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] except_type;
    } fetch_entry_t;

    // Fetch exception vector; a misaligned PC shares the address-error bit with user access.
    function automatic logic [31:0] except_vector(input logic [1:0] pc_lo, input logic miss,
                                                  input logic invalid, input logic user);
        logic [31:0] vec;
        vec                  = 32'h0000_0000;
        vec[EXC_ADEL_BIT]    = (pc_lo != 2'b00) | user;
        vec[EXC_TLBMISS_BIT] = miss;
        vec[EXC_TLBINV_BIT]  = invalid;
        return vec;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with clear; a push into a full FIFO is accepted only alongside a pop.
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNTW-1:0]  count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1'b1);
        end
    endfunction

    assign full      = (count_r == CNTW'(DEPTH));
    assign empty     = (count_r == {CNTW{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | pop);

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNTW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNTW'(1'b1);
                2'b01:   count_r <= count_r - CNTW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue_checker.sv
// Protocol and bookkeeping invariants of the fetch queue.
module ifetch_queue_checker #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          inst_data_ok,
    input logic          accept,
    input logic          pend_full,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] live,
    input logic [CW-1:0] pend_count
);

    // Responses only for requests that are actually outstanding; one pending PC per live request.
    a_dok_needs_inflight: assert property (@(posedge clk) disable iff (rst)
        inst_data_ok |-> (inflight != {CW{1'b0}}));
    a_pend_tracks_live: assert property (@(posedge clk) disable iff (rst)
        pend_count == live);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        accept |-> !pend_full);

endmodule

// File: rtl/ifetch_queue.sv
// Pipelined instruction fetch: owns the PC, keeps several requests in flight and
// delivers instructions or a precise fetch exception in order to decode.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          BUF_DEPTH       = 4,
    parameter logic [31:0] RESET_PC        = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        inst_uncached,
    output logic [31:0] mmu_virt_addr,
    output logic        mmu_en,
    input  logic [31:0] mmu_phys_addr,
    input  logic        mmu_uncached,
    input  logic        mmu_except_miss,
    input  logic        mmu_except_invalid,
    input  logic        mmu_except_user,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_except_type
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r;
    logic [CW-1:0] inflight_r, discard_r, live_s, inflight_dec_s;
    logic [31:0]  exc_vec_s;
    logic         has_exc_s, issue_s, accept_s, live_dok_s, drop_dok_s, exc_push_s;
    logic [31:0]  pend_head_s;
    logic         pend_full_s, pend_empty_s;
    logic [CW-1:0] pend_count_s;
    fetch_entry_t buf_entry_s, buf_head_s;
    logic         buf_push_s, buf_pop_s, buf_full_s, buf_empty_s;
    logic [BW-1:0] buf_count_s;

    // Issue decision: only registered state, redirect and the MMU result feed inst_req.
    always_comb begin
        exc_vec_s      = except_vector(pc_r[1:0], mmu_except_miss, mmu_except_invalid, mmu_except_user);
        has_exc_s      = |exc_vec_s;
        live_s         = inflight_r - discard_r;
        inflight_dec_s = inflight_r - CW'(inst_data_ok);
        if (!rst && !redirect_valid && (state_r == ST_RUN) && !has_exc_s &&
            (inflight_r < CW'(MAX_OUTSTANDING)) &&
            ((32'(live_s) + 32'(buf_count_s)) < 32'(BUF_DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        accept_s   = issue_s & inst_addr_ok;
        live_dok_s = inst_data_ok & ~redirect_valid & (discard_r == {CW{1'b0}});
        drop_dok_s = inst_data_ok & ~redirect_valid & (discard_r != {CW{1'b0}});
    end

    // Next state and the exception-entry push that retires DRAIN.
    always_comb begin
        state_nxt_s = state_r;
        exc_push_s  = 1'b0;
        if (redirect_valid) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (has_exc_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if ((live_s == {CW{1'b0}}) && !buf_full_s) begin
                        exc_push_s  = 1'b1;
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_HALT: state_nxt_s = ST_HALT;
                default: state_nxt_s = ST_RUN;
            endcase
        end
    end

    // Output-buffer write data: exception entry or returned instruction.
    always_comb begin
        if (exc_push_s) begin
            buf_entry_s = '{pc: pc_r, inst: 32'h0000_0000, except_type: exc_vec_s};
        end else begin
            buf_entry_s = '{pc: pend_head_s, inst: inst_rdata, except_type: 32'h0000_0000};
        end
        buf_push_s = live_dok_s | exc_push_s;
        buf_pop_s  = ~buf_empty_s & out_ready;
    end

    // PC, FSM and outstanding-request bookkeeping; a redirect overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            inflight_r <= {CW{1'b0}};
            discard_r  <= {CW{1'b0}};
        end else if (redirect_valid) begin
            state_r    <= ST_RUN;
            pc_r       <= redirect_pc;
            inflight_r <= inflight_dec_s;
            discard_r  <= inflight_dec_s;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= inflight_dec_s + CW'(accept_s);
            if (accept_s) begin
                pc_r <= pc_r + 32'd4;
            end
            if (drop_dok_s) begin
                discard_r <= discard_r - CW'(1'b1);
            end
        end
    end

    fifo_sync #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pend_fifo (
        .clk(clk), .rst(rst), .push(accept_s), .pop(live_dok_s), .clear(redirect_valid),
        .push_data(pc_r), .pop_data(pend_head_s), .full(pend_full_s), .empty(pend_empty_s),
        .count(pend_count_s)
    );

    fifo_sync #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_out_buf (
        .clk(clk), .rst(rst), .push(buf_push_s), .pop(buf_pop_s), .clear(redirect_valid),
        .push_data(buf_entry_s), .pop_data(buf_head_s), .full(buf_full_s), .empty(buf_empty_s),
        .count(buf_count_s)
    );

    ifetch_queue_checker #(.CW(CW)) u_checker (
        .clk(clk), .rst(rst), .inst_data_ok(inst_data_ok), .accept(accept_s),
        .pend_full(pend_full_s | (pend_empty_s & pend_full_s)), .inflight(inflight_r),
        .live(live_s), .pend_count(pend_count_s)
    );

    assign inst_req        = issue_s;
    assign inst_wr         = 1'b0;
    assign inst_size       = 2'b10;
    assign inst_addr       = mmu_phys_addr;
    assign inst_wdata      = 32'h0000_0000;
    assign inst_uncached   = mmu_uncached;
    assign mmu_virt_addr   = pc_r;
    assign mmu_en          = 1'b1;
    assign out_valid       = ~buf_empty_s;
    assign out_pc          = buf_head_s.pc;
    assign out_inst        = buf_head_s.inst;
    assign out_except_type = buf_head_s.except_type;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue with an in-order sram-like memory and MMU model.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_req, inst_wr, inst_uncached, mmu_en, out_valid;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, mmu_virt_addr, out_pc, out_inst, out_except_type;
    logic [31:0] inst_rdata = 32'h0;
    logic        inst_addr_ok = 1'b1;
    logic        inst_data_ok = 1'b0;
    logic [31:0] mmu_phys_addr;
    logic        mmu_uncached, mmu_except_miss;
    logic        mmu_except_invalid = 1'b0;
    logic        mmu_except_user = 1'b0;
    logic        out_ready = 1'b1;
    logic        mem_hold = 1'b0;
    logic        miss_en = 1'b0;
    logic [31:0] miss_va = 32'h0;
    logic [31:0] mq [$];
    int          n_checks = 0;
    int          n_pass = 0;

    ifetch_queue dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_uncached(inst_uncached), .mmu_virt_addr(mmu_virt_addr),
        .mmu_en(mmu_en), .mmu_phys_addr(mmu_phys_addr), .mmu_uncached(mmu_uncached),
        .mmu_except_miss(mmu_except_miss), .mmu_except_invalid(mmu_except_invalid),
        .mmu_except_user(mmu_except_user), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_except_type(out_except_type)
    );

    always #5 clk = ~clk;

    assign mmu_phys_addr   = mmu_virt_addr & 32'h1FFF_FFFF;
    assign mmu_uncached    = (mmu_virt_addr[31:29] == 3'b101);
    assign mmu_except_miss = miss_en && (mmu_virt_addr == miss_va);

    // In-order memory: answers each accepted request one cycle later unless held.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            inst_data_ok <= 1'b0;
        end else begin
            if (inst_data_ok) void'(mq.pop_front());
            if (inst_req && inst_addr_ok) mq.push_back(inst_addr);
            if (!mem_hold && mq.size() > 0) begin
                inst_data_ok <= 1'b1;
                inst_rdata   <= mq[0] ^ 32'hA5A5_0000;
            end else begin
                inst_data_ok <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return (pc & 32'h1FFF_FFFF) ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        miss_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    // Waits for the next head entry with out_ready=1 and consumes it.
    task automatic wait_out(output logic [31:0] pc, output logic [31:0] inst,
                            output logic [31:0] exc, output logic got);
        got = 1'b0; pc = 32'h0; inst = 32'h0; exc = 32'h0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (out_valid) begin
                pc = out_pc; inst = out_inst; exc = out_except_type; got = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        out_ready = 1'b1; mem_hold = 1'b0;
        rst = 1'b1;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (inst_req !== 1'b0) $display("FAIL reset_inst_req got %b want 0", inst_req); else n_pass++;
        n_checks++; if (dut.inflight_r !== 2'd0) $display("FAIL reset_inflight got %0d want 0", dut.inflight_r); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if ({inst_req, inst_addr} !== {1'b1, 32'h1FC0_0000}) $display("FAIL first_req got %b %h want 1 1fc00000", inst_req, inst_addr); else n_pass++;
        n_checks++; if (mmu_virt_addr !== 32'hBFC0_0000) $display("FAIL reset_pc got %h want bfc00000", mmu_virt_addr); else n_pass++;
        n_checks++; if ({inst_wr, inst_size, inst_wdata, mmu_en} !== {1'b0, 2'b10, 32'h0, 1'b1}) $display("FAIL req_consts got %b %b %h %b", inst_wr, inst_size, inst_wdata, mmu_en); else n_pass++;
        n_checks++; if (inst_uncached !== 1'b1) $display("FAIL uncached got %b want 1", inst_uncached); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_early got %b want 0", out_valid); else n_pass++;
        step();
        for (int k = 0; k < 3; k++) begin
            pc = 32'hBFC0_0000 + 32'(4 * k);
            n_checks++;
            if ({out_valid, out_pc, out_inst, out_except_type} !== {1'b1, pc, exp_inst(pc), 32'h0})
                $display("FAIL stream_%0d got v=%b pc=%h inst=%h exc=%h want pc=%h", k, out_valid, out_pc, out_inst, out_except_type, pc);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        logic [31:0] pc, inst, exc, want;
        logic got;
        out_ready = 1'b0;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (inst_req && inst_addr_ok) cnt++;
            step();
        end
        n_checks++; if (cnt !== 4) $display("FAIL bp_accepts got %0d want 4", cnt); else n_pass++;
        n_checks++; if (inst_req !== 1'b0) $display("FAIL bp_req_stopped got %b want 0", inst_req); else n_pass++;
        n_checks++; if ({out_valid, out_pc} !== {1'b1, 32'hBFC0_0000}) $display("FAIL bp_head got %b %h want 1 bfc00000", out_valid, out_pc); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_out(pc, inst, exc, got);
            want = 32'hBFC0_0000 + 32'(4 * k);
            n_checks++;
            if ({got, pc, inst, exc} !== {1'b1, want, exp_inst(want), 32'h0})
                $display("FAIL bp_drain_%0d got %b pc=%h inst=%h exc=%h want pc=%h", k, got, pc, inst, exc, want);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        logic [31:0] pc, inst, exc, want;
        logic got;
        out_ready = 1'b1; mem_hold = 1'b1;
        do_reset();
        step(); step();
        n_checks++; if ({inst_req, dut.inflight_r} !== {1'b0, 2'd2}) $display("FAIL rd_limit got %b %0d want 0 2", inst_req, dut.inflight_r); else n_pass++;
        mem_hold = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0180;
        #1;
        n_checks++; if (inst_req !== 1'b0) $display("FAIL rd_req_in_redirect got %b want 0", inst_req); else n_pass++;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rd_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if ({inst_req, inst_addr} !== {1'b1, 32'h0000_0180}) $display("FAIL rd_new_req got %b %h want 1 00000180", inst_req, inst_addr); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            wait_out(pc, inst, exc, got);
            want = 32'h8000_0180 + 32'(4 * k);
            n_checks++;
            if ({got, pc, inst, exc} !== {1'b1, want, exp_inst(want), 32'h0})
                $display("FAIL rd_out_%0d got %b pc=%h inst=%h exc=%h want pc=%h", k, got, pc, inst, exc, want);
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] pc, inst, exc;
        logic got;
        int busy;
        out_ready = 1'b1;
        do_reset();
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (inst_req !== 1'b0) $display("FAIL mis_no_issue got %b want 0", inst_req); else n_pass++;
        wait_out(pc, inst, exc, got);
        n_checks++;
        if ({got, pc, inst, exc} !== {1'b1, 32'h8000_0002, 32'h0, 32'h0000_4000})
            $display("FAIL mis_entry got %b pc=%h inst=%h exc=%h want 80000002 0 00004000", got, pc, inst, exc);
        else n_pass++;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (inst_req || out_valid) busy++;
            step();
        end
        n_checks++; if (busy !== 0) $display("FAIL mis_halt got %0d busy cycles want 0", busy); else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        wait_out(pc, inst, exc, got);
        n_checks++;
        if ({got, pc, inst, exc} !== {1'b1, 32'h8000_0200, exp_inst(32'h8000_0200), 32'h0})
            $display("FAIL mis_resume got %b pc=%h inst=%h exc=%h want 80000200", got, pc, inst, exc);
        else n_pass++;
    endtask

    task automatic test_tlb_miss();
        logic [31:0] pc, inst, exc, want;
        logic got;
        out_ready = 1'b1;
        do_reset();
        miss_va = 32'h0040_0010; miss_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_out(pc, inst, exc, got);
            want = 32'h0040_0000 + 32'(4 * k);
            n_checks++;
            if ({got, pc, inst, exc} !== {1'b1, want, exp_inst(want), 32'h0})
                $display("FAIL tlb_out_%0d got %b pc=%h inst=%h exc=%h want pc=%h", k, got, pc, inst, exc, want);
            else n_pass++;
        end
        wait_out(pc, inst, exc, got);
        n_checks++;
        if ({got, pc, inst, exc} !== {1'b1, 32'h0040_0010, 32'h0, 32'h0000_8000})
            $display("FAIL tlb_entry got %b pc=%h inst=%h exc=%h want 00400010 0 00008000", got, pc, inst, exc);
        else n_pass++;
        n_checks++; if ({inst_req, out_valid} !== 2'b00) $display("FAIL tlb_halt got %b%b want 00", inst_req, out_valid); else n_pass++;
        miss_en = 1'b0;
    endtask

    task automatic test_reset_midburst();
        logic [31:0] pc, inst, exc;
        logic got;
        out_ready = 1'b1;
        do_reset();
        step(); step();
        rst = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mb_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (dut.inflight_r !== 2'd0) $display("FAIL mb_inflight got %0d want 0", dut.inflight_r); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if ({inst_req, mmu_virt_addr} !== {1'b1, 32'hBFC0_0000}) $display("FAIL mb_restart got %b %h want 1 bfc00000", inst_req, mmu_virt_addr); else n_pass++;
        wait_out(pc, inst, exc, got);
        n_checks++;
        if ({got, pc, inst, exc} !== {1'b1, 32'hBFC0_0000, exp_inst(32'hBFC0_0000), 32'h0})
            $display("FAIL mb_first got %b pc=%h inst=%h exc=%h want bfc00000", got, pc, inst, exc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_tlb_miss();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
